reg_bus_rr_arbiter: RTL

REG_BUS_RR_ARBITER -- requirements
Module: reg_bus_rr_arbiter

---
 rtl/reg_bus_rr_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_rr_arbiter
//  Description : Round-robin arbiter letting NUM_REQ requesters share one
//                register bus. A single transfer is in flight at a time. The
//                winner's request is latched so the downstream fields stay
//                stable for the whole transfer. An optional BUSY-cycle limit
//                aborts a stalled transfer with an error completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    // requester side
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0]                req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [DATA_WIDTH-1:0]             req_rdata_o,
    output logic                              req_error_o,
    // downstream register bus
    output logic                              reg_valid_o,
    output logic                              reg_write_o,
    output logic [ADDR_WIDTH-1:0]             reg_addr_o,
    output logic [DATA_WIDTH-1:0]             reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           reg_wstrb_o,
    input  logic                              reg_ready_i,
    input  logic [DATA_WIDTH-1:0]             reg_rdata_i,
    input  logic                              reg_error_i,
    // status
    output logic [$clog2(NUM_REQ)-1:0]        grant_idx_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] C_LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit               C_TO_EN     = (TIMEOUT_CYCLES > 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Arbitration history and latched transfer
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [CNT_W-1:0]       r_cnt;

    // Arbitration result
    logic                   w_any_req;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_sel_write;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [STRB_W-1:0]      w_sel_wstrb;
    int                     w_best;
    int                     w_dist;

    // FSM control
    logic                   w_grant;
    logic                   w_timeout;
    logic [NUM_REQ-1:0]     w_grant_onehot;

    assign w_any_req   = |req_valid_i;
    assign grant_idx_o = r_grant_idx;

    // Round-robin pick: each valid requester is ranked by its distance from
    // the slot just after the last grant; the smallest distance wins.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (req_valid_i[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_sel_idx   = IDX_W'(j);
                w_sel_write = req_write_i[j];
                w_sel_addr  = req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wstrb = req_wstrb_i[j*STRB_W +: STRB_W];
            end
        end
    end

    // Decode the granted index into the completion pulse vector.
    always_comb begin
        w_grant_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_grant_onehot[j] = (r_grant_idx == IDX_W'(j));
        end
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode. Downstream fields are driven only in
    // BUSY so the bus is quiet (all zero) whenever no transfer is in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        req_ready_o = '0;
        req_rdata_o = '0;
        req_error_o = 1'b0;
        busy_o      = 1'b0;
        timeout_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_o      = 1'b1;
                reg_valid_o = 1'b1;
                reg_write_o = r_write;
                reg_addr_o  = r_addr;
                reg_wdata_o = r_wdata;
                reg_wstrb_o = r_wstrb;
                // A slave response wins over a timeout in the same cycle.
                if (reg_ready_i) begin
                    req_ready_o = w_grant_onehot;
                    req_rdata_o = reg_rdata_i;
                    req_error_o = reg_error_i;
                    w_state_nxt = S_IDLE;
                end else if (C_TO_EN && (r_cnt == C_CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    req_ready_o = w_grant_onehot;
                    req_error_o = 1'b1;
                    timeout_o   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, request latch and stall counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= C_LAST_RST;
            r_grant_idx  <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_sel_idx;
            r_grant_idx  <= w_sel_idx;
            r_write      <= w_sel_write;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_wstrb      <= w_sel_wstrb;
            r_cnt        <= '0;
        end else if ((r_state == S_BUSY) && !reg_ready_i && !w_timeout) begin
            r_cnt        <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
